// File: rtl/msrv_unity_pkg.sv
// Shared types and round-robin helper for the Msrv unity arbiter.
// Combinational helper only; no state or latency.
// No backpressure; the caller decides when a pick is consumed.
package msrv_unity_pkg;

  localparam int CUnityOwnerW = 3;
  localparam int CMaxCores    = 1 << CUnityOwnerW;

  typedef enum logic [1:0] {
    IIdle  = 2'd0,
    IGrant = 2'd1,
    IDrain = 2'd2
  } unity_state_e;

  typedef struct packed {
    logic                    vld;
    logic [CUnityOwnerW-1:0] idx;
  } rr_pick_t;

  // First set bit of mask searching upward from ptr+1, wrapping at core_cnt.
  function automatic rr_pick_t rr_pick(input logic [CMaxCores-1:0]    mask,
                                       input logic [CUnityOwnerW-1:0] ptr,
                                       input int unsigned             core_cnt);
    rr_pick_t              res;
    logic [CUnityOwnerW:0] cand;
    logic [CUnityOwnerW:0] cnt_w;
    res   = '0;
    cnt_w = (CUnityOwnerW+1)'(core_cnt);
    for (int i = 1; i <= CMaxCores; i++) begin
      cand = {1'b0, ptr} + (CUnityOwnerW+1)'(i);
      if (cand >= cnt_w) cand = cand - cnt_w;
      if (((CUnityOwnerW+1)'(i) <= cnt_w) && !res.vld && mask[cand[CUnityOwnerW-1:0]]) begin
        res.vld = 1'b1;
        res.idx = cand[CUnityOwnerW-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/msrv_rr_pick.sv
// Round-robin picker over the per-core unity requests.
// Purely combinational, zero latency.
// No backpressure; result is valid whenever any request bit is set.
module msrv_rr_pick
  import msrv_unity_pkg::*;
#(
  parameter int CCoreCnt = 4
) (
  input  logic [CCoreCnt-1:0]     req,
  input  logic [CUnityOwnerW-1:0] ptr,
  output logic                    vld,
  output logic [CUnityOwnerW-1:0] idx
);

  logic [CMaxCores-1:0] mask;
  rr_pick_t             pick;

  always_comb begin
    mask                 = '0;
    mask[CCoreCnt-1:0]   = req;
    pick                 = rr_pick(mask, ptr, CCoreCnt);
  end

  assign vld = pick.vld;
  assign idx = pick.idx;

endmodule

// File: rtl/msrv_unity_arb.sv
// Round-robin mutual-exclusion arbiter with drain-before-handoff and watchdog.
// Grant one cycle after request; next grant at earliest three cycles after release.
// Non-owner requests are not latched; requesters must hold their level.
module msrv_unity_arb
  import msrv_unity_pkg::*;
#(
  parameter int CCoreCnt  = 4,
  parameter int CTimeoutW = 16
) (
  input  logic                    AClkH,
  input  logic                    AResetH,
  input  logic [CCoreCnt-1:0]     AUnityReq,
  input  logic [CCoreCnt-1:0]     AMemPend,
  output logic [CCoreCnt-1:0]     AUnityAck,
  output logic                    AUnityBusy,
  output logic [CUnityOwnerW-1:0] AUnityOwner,
  input  logic [CTimeoutW-1:0]    ATimeoutLimit,
  output logic                    AUnityTimeout,
  input  logic                    AToClr
);

  unity_state_e            state, state_nxt;
  logic [CUnityOwnerW-1:0] owner;
  logic [CUnityOwnerW-1:0] rr_ptr;
  logic [CTimeoutW-1:0]    wd_cnt, wd_inc;
  logic [CMaxCores-1:0]    req_ext, pend_ext;
  logic                    owner_req, owner_pend;
  logic                    pick_vld;
  logic [CUnityOwnerW-1:0] pick_idx;
  logic [CCoreCnt-1:0]     grant_vec;
  logic                    to_set;

  msrv_rr_pick #(.CCoreCnt(CCoreCnt)) u_pick (
    .req (AUnityReq),
    .ptr (rr_ptr),
    .vld (pick_vld),
    .idx (pick_idx)
  );

  assign grant_vec = {{(CCoreCnt-1){1'b0}}, 1'b1} << pick_idx;

  // Widen to the owner index range so a 3-bit owner selects without truncation.
  always_comb begin
    req_ext                  = '0;
    pend_ext                 = '0;
    req_ext[CCoreCnt-1:0]    = AUnityReq;
    pend_ext[CCoreCnt-1:0]   = AMemPend;
    owner_req                = req_ext[owner];
    owner_pend               = pend_ext[owner];
    wd_inc                   = (&wd_cnt) ? wd_cnt : wd_cnt + CTimeoutW'(1);
    to_set                   = (state == IGrant) && (|ATimeoutLimit) && (wd_inc == ATimeoutLimit);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IIdle:   if (pick_vld)    state_nxt = IGrant;
      IGrant:  if (!owner_req)  state_nxt = IDrain;
      IDrain:  if (!owner_pend) state_nxt = IIdle;
      default:                  state_nxt = IIdle;
    endcase
  end

  always_ff @(posedge AClkH) begin
    if (AResetH) begin
      state         <= IIdle;
      owner         <= '0;
      rr_ptr        <= CUnityOwnerW'(CCoreCnt - 1);
      wd_cnt        <= '0;
      AUnityAck     <= '0;
      AUnityTimeout <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IIdle: begin
          if (pick_vld) begin
            owner     <= pick_idx;
            AUnityAck <= grant_vec;
          end
        end
        IGrant: begin
          wd_cnt <= wd_inc;
          if (!owner_req) AUnityAck <= '0;
        end
        IDrain: begin
          if (!owner_pend) begin
            rr_ptr <= owner;
            wd_cnt <= '0;
          end
        end
        default: ;
      endcase
      // Setting takes precedence over a coincident clear pulse.
      if (to_set)      AUnityTimeout <= 1'b1;
      else if (AToClr) AUnityTimeout <= 1'b0;
    end
  end

  assign AUnityBusy  = (state != IIdle);
  assign AUnityOwner = owner;

endmodule

// File: tb/tb_msrv_unity_arb.sv
// Scoreboard bench for msrv_unity_arb: expected grant order is queued at
// stimulus time and matched against each rising ack.
module tb_msrv_unity_arb;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, pend, ack;
  logic       busy, timeout, toclr;
  logic [2:0] owner;
  logic [15:0] limit;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int idle_run = 99;
  int mon_e;
  logic [3:0] prev_ack = '0;
  int n;

  always #5 clk = ~clk;

  msrv_unity_arb #(.CCoreCnt(4), .CTimeoutW(16)) dut (
    .AClkH         (clk),
    .AResetH       (rst),
    .AUnityReq     (req),
    .AMemPend      (pend),
    .AUnityAck     (ack),
    .AUnityBusy    (busy),
    .AUnityOwner   (owner),
    .ATimeoutLimit (limit),
    .AUnityTimeout (timeout),
    .AToClr        (toclr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int cyc);
    repeat (cyc) @(negedge clk);
  endtask

  task automatic wait_grant(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (ack == '0 && cyc < 40);
    if (ack == '0) chk("grant_wait", 0, 1);
  endtask

  // Every rising ack must match the next queued core and follow >=2 idle cycles.
  always @(negedge clk) begin
    if (rst) begin
      idle_run = 99;
      prev_ack = '0;
    end else begin
      if (ack != '0 && prev_ack == '0) begin
        if (exp_q.size() == 0) begin
          chk("unexp_grant", 32'(ack), 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("grant_ack", 32'(ack), 32'(1 << mon_e));
          chk("grant_owner", 32'(owner), 32'(mon_e));
          chk("grant_gap", 32'(idle_run >= 2), 1);
        end
        idle_run = 0;
      end else if (ack == '0) begin
        idle_run++;
      end
      prev_ack = ack;
    end
  end

  initial begin
    rst = 1'b1; req = '0; pend = '0; limit = '0; toclr = 1'b0;
    tick(2);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_to", 32'(timeout), 0);
    rst = 1'b0;

    // Basic grant, release and handoff to core 2.
    exp_q.push_back(0); exp_q.push_back(2);
    req = 4'b0101;
    tick(1);
    chk("t1_lat", 32'(ack), 32'h1);
    req = 4'b0100;
    tick(1); chk("t1_rel_ack", 32'(ack), 0); chk("t1_rel_busy", 32'(busy), 1);
    tick(1); chk("t1_idle_ack", 32'(ack), 0); chk("t1_idle_busy", 32'(busy), 0);
    tick(1); chk("t1_next", 32'(ack), 32'h4); chk("t1_owner", 32'(owner), 2);
    req = '0;
    tick(3);

    // All four contend; each holds 5 cycles then re-raises during drain.
    rst = 1'b1; tick(1); rst = 1'b0;
    for (int k = 0; k < 5; k++) exp_q.push_back(k % 4);
    req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_grant(n);
      chk("t2_wait", 32'(n), (k == 0) ? 1 : 2);
      tick(4);
      chk("t2_hold", 32'(ack), 32'(1 << (k % 4)));
      req[k % 4] = 1'b0;
      tick(1);
      if (k < 4) req[k % 4] = 1'b1;
    end
    req = '0;
    tick(3);

    // Drain stall: core 1 leaves with traffic pending for 7 cycles.
    exp_q.push_back(1);
    req = 4'b0010;
    wait_grant(n);
    exp_q.push_back(2);
    req = 4'b0100; pend = 4'b0010;
    for (int i = 0; i < 7; i++) begin
      tick(1);
      chk("t3_busy", 32'(busy), 1);
      chk("t3_ack", 32'(ack), 0);
    end
    pend = '0;
    wait_grant(n);
    chk("t3_wait", 32'(n), 2);
    chk("t3_owner", 32'(owner), 2);
    req = '0;
    tick(3);

    // Watchdog at limit 10, sticky past release, cleared by pulse.
    exp_q.push_back(3);
    limit = 16'd10; req = 4'b1000;
    wait_grant(n);
    tick(9);  chk("t4_to_early", 32'(timeout), 0);
    tick(1);  chk("t4_to_set", 32'(timeout), 1);
    tick(10); chk("t4_still_own", 32'(ack), 32'h8);
    req = '0;
    tick(3);  chk("t4_sticky", 32'(timeout), 1);
    toclr = 1'b1; tick(1); toclr = 1'b0;
    chk("t4_clr", 32'(timeout), 0);

    // Set beats a coincident clear.
    exp_q.push_back(0);
    limit = 16'd5; req = 4'b0001; toclr = 1'b1;
    wait_grant(n);
    tick(4); chk("t4_sw_early", 32'(timeout), 0);
    tick(1); chk("t4_setwins", 32'(timeout), 1);
    tick(1); chk("t4_clr_after", 32'(timeout), 0);
    toclr = 1'b0; req = '0;
    tick(3);

    // Disabled watchdog never fires.
    exp_q.push_back(1);
    limit = '0; req = 4'b0010;
    wait_grant(n);
    tick(20); chk("t4_disabled", 32'(timeout), 0);
    req = '0;
    tick(3);

    // Reset mid-grant of core 3, then cores 0 and 3 contend.
    exp_q.push_back(3);
    limit = 16'd3; req = 4'b1000; pend = 4'b1000;
    wait_grant(n);
    tick(5); chk("t5_pre_to", 32'(timeout), 1);
    rst = 1'b1;
    tick(1);
    chk("t5_ack", 32'(ack), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_owner", 32'(owner), 0);
    chk("t5_to", 32'(timeout), 0);
    rst = 1'b0; limit = '0;
    exp_q.push_back(0);
    req = 4'b1001;
    wait_grant(n);
    chk("t5_owner0", 32'(owner), 0);
    req = '0; pend = '0;
    tick(3);

    // Single-cycle pulse from core 2 while core 1 owns is lost.
    exp_q.push_back(1);
    req = 4'b0010;
    wait_grant(n);
    req = 4'b0110; tick(1); req = 4'b0010;
    tick(3);
    req = '0;
    tick(8);
    chk("t6_ack", 32'(ack), 0);
    chk("t6_busy", 32'(busy), 0);

    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
